// File: rtl/spike_gen_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : spike_gen_scheduler_if
// Description : Programming channel and TagCt output channel of the
//               spike-generator scheduler. The slave modport is the scheduler
//               side; the master modport is the side that programs the bank
//               and consumes emitted tag/count words.
// Revision    : 1.0  initial release
// ============================================================================
interface spike_gen_scheduler_if #(
  parameter int NGENS   = 8,
  parameter int NPERIOD = 16,
  parameter int NTAG    = 11,
  parameter int NCT     = 9
);
  // Programming channel
  logic [NGENS-1:0]   prog_gen_idx;
  logic [NPERIOD-1:0] prog_period;
  logic [NPERIOD-1:0] prog_ticks;
  logic [NTAG-1:0]    prog_tag;
  logic               prog_sign;
  logic               prog_v;
  logic               prog_a;

  // TagCt output channel
  logic [NTAG-1:0]    out_tag;
  logic [NCT-1:0]     out_ct;
  logic               out_v;
  logic               out_a;

  modport master (
    output prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_sign, prog_v,
    input  prog_a,
    input  out_tag, out_ct, out_v,
    output out_a
  );

  modport slave (
    input  prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_sign, prog_v,
    output prog_a,
    output out_tag, out_ct, out_v,
    input  out_a
  );
endinterface
`default_nettype wire

// File: rtl/spike_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : spike_gen_scheduler
// Description : Sequences the spike-generator bank. Holds per-generator
//               period/ticks/tag/sign, scans generators 0..gens_used once per
//               time-unit pulse and emits one tag/count word per expiring
//               generator on the TagCt channel.
// Options     : SPIKE_GEN_STATS_EN adds spike_count and max_scan_cycles.
// Revision    : 1.0  initial release
// ============================================================================
module spike_gen_scheduler #(
  parameter int NGENS   = 8,
  parameter int NPERIOD = 16,
  parameter int NTAG    = 11,
  parameter int NCT     = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 time_unit_pulse,
  input  logic [NGENS-1:0]     gens_used,
  input  logic [2**NGENS-1:0]  gens_en,
  spike_gen_scheduler_if.slave bus,
  output logic                 busy,
  output logic                 overrun
`ifdef SPIKE_GEN_STATS_EN
  ,
  output logic [31:0]          spike_count,
  output logic [15:0]          max_scan_cycles
`endif
);

  localparam int NENT = 2**NGENS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [NGENS-1:0] idx, idx_nxt;
  logic             pending;

  // Generator bank, packed so the whole bank clears in one reset assignment
  logic [NENT-1:0][NPERIOD-1:0] period_mem;
  logic [NENT-1:0][NPERIOD-1:0] ticks_mem;
  logic [NENT-1:0][NTAG-1:0]    tag_mem;
  logic [NENT-1:0]              sign_mem;

  // Registered output word
  logic [NTAG-1:0] emit_tag;
  logic [NCT-1:0]  emit_ct;
  logic            emit_v;

  logic [NPERIOD-1:0] cur_period;
  logic [NPERIOD-1:0] cur_ticks;
  logic               active;
  logic               last;
  logic               start;
  logic               prog_xfer;
  logic               out_xfer;
  logic               fire;
  logic               ticks_we;
  logic [NPERIOD-1:0] ticks_wdata;

  assign cur_period = period_mem[idx];
  assign cur_ticks  = ticks_mem[idx];
  assign active     = gens_en[idx] && (cur_period != '0);
  // Also stop at the top index so a gens_used lowered mid-scan cannot wrap
  assign last       = (idx == gens_used) || (&idx);
  assign start      = (state == IDLE) && (time_unit_pulse || pending);
  assign prog_xfer  = bus.prog_v && bus.prog_a;
  assign out_xfer   = emit_v && bus.out_a;

  assign busy        = (state != IDLE);
  assign bus.prog_a  = (state == IDLE) && !pending && !reset;
  assign bus.out_tag = emit_tag;
  assign bus.out_ct  = emit_ct;
  assign bus.out_v   = emit_v;

  // State and scan index registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state, index stepping and tick update decisions
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    fire        = 1'b0;
    ticks_we    = 1'b0;
    ticks_wdata = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
        end
      end
      SCAN: begin
        if (active) begin
          ticks_we = 1'b1;
          if (cur_ticks == '0) begin
            ticks_wdata = cur_period - NPERIOD'(1);
            fire        = 1'b1;
            state_nxt   = EMIT;
          end else begin
            ticks_wdata = cur_ticks - NPERIOD'(1);
          end
        end
        if (!fire) begin
          if (last) state_nxt = IDLE;
          else      idx_nxt   = idx + NGENS'(1);
        end
      end
      EMIT: begin
        if (out_xfer) begin
          if (last) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = SCAN;
            idx_nxt   = idx + NGENS'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Generator bank: programming writes only in IDLE, tick updates only in SCAN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_mem <= '0;
      ticks_mem  <= '0;
      tag_mem    <= '0;
      sign_mem   <= '0;
    end else if (prog_xfer) begin
      period_mem[bus.prog_gen_idx] <= bus.prog_period;
      ticks_mem[bus.prog_gen_idx]  <= bus.prog_ticks;
      tag_mem[bus.prog_gen_idx]    <= bus.prog_tag;
      sign_mem[bus.prog_gen_idx]   <= bus.prog_sign;
    end else if (ticks_we) begin
      ticks_mem[idx] <= ticks_wdata;
    end
  end

  // Output word load on a fire, valid drop after the transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      emit_tag <= '0;
      emit_ct  <= '0;
      emit_v   <= 1'b0;
    end else if (fire) begin
      emit_tag <= tag_mem[idx];
      emit_ct  <= sign_mem[idx] ? '1 : NCT'(1);
      emit_v   <= 1'b1;
    end else if (out_xfer) begin
      emit_v   <= 1'b0;
    end
  end

  // Pulses arriving during a scan are remembered once; a second one is lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (state == IDLE) begin
      if (start) pending <= 1'b0;
    end else if (time_unit_pulse) begin
      if (pending) overrun <= 1'b1;
      pending <= 1'b1;
    end
  end

`ifdef SPIKE_GEN_STATS_EN
  logic [15:0] scan_cycles;

  // Transfer counter and longest SCAN-entry-to-IDLE duration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_count     <= '0;
      max_scan_cycles <= '0;
      scan_cycles     <= '0;
    end else begin
      if (out_xfer) spike_count <= spike_count + 32'd1;
      if (start) begin
        scan_cycles <= 16'd1;
      end else if (state != IDLE) begin
        if (state_nxt == IDLE) begin
          if (scan_cycles > max_scan_cycles) max_scan_cycles <= scan_cycles;
        end else if (scan_cycles != 16'hFFFF) begin
          scan_cycles <= scan_cycles + 16'd1;
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spike_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_gen_scheduler
// Description : Directed self-checking bench for spike_gen_scheduler.
//               Build with SPIKE_GEN_STATS_EN defined to cover the counters.
// Revision    : 1.0  initial release
// ============================================================================
module tb_spike_gen_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         time_unit_pulse;
  logic [7:0]   gens_used;
  logic [255:0] gens_en;
  logic         busy;
  logic         overrun;
`ifdef SPIKE_GEN_STATS_EN
  logic [31:0]  spike_count;
  logic [15:0]  max_scan_cycles;
`endif

  spike_gen_scheduler_if bus ();

  spike_gen_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .time_unit_pulse (time_unit_pulse),
    .gens_used       (gens_used),
    .gens_en         (gens_en),
    .bus             (bus),
    .busy            (busy),
    .overrun         (overrun)
`ifdef SPIKE_GEN_STATS_EN
    ,
    .spike_count     (spike_count),
    .max_scan_cycles (max_scan_cycles)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int words  = 0;
  logic [10:0] got_tags[$];
  logic [8:0]  got_cts[$];

  // Log every TagCt transfer, sampled mid-cycle before the edge that takes it
  always @(negedge clk) begin
    if (!reset && bus.out_v && bus.out_a) begin
      got_tags.push_back(bus.out_tag);
      got_cts.push_back(bus.out_ct);
      words++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] tag_at(input int i);
    return (i < got_tags.size()) ? got_tags[i] : 11'h7FF;
  endfunction

  function automatic logic [8:0] ct_at(input int i);
    return (i < got_cts.size()) ? got_cts[i] : 9'h0AA;
  endfunction

  task automatic pulse();
    time_unit_pulse = 1'b1;
    @(posedge clk); #1;
    time_unit_pulse = 1'b0;
  endtask

  task automatic program_gen(input int gi, input int period, input int ticks,
                             input int tag, input bit sign);
    int n;
    n = 0;
    bus.prog_gen_idx = 8'(gi);
    bus.prog_period  = 16'(period);
    bus.prog_ticks   = 16'(ticks);
    bus.prog_tag     = 11'(tag);
    bus.prog_sign    = sign;
    bus.prog_v       = 1'b1;
    while (!bus.prog_a && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.prog_v = 1'b0;
    check("prog_accept", 32'(n < 200), 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Wait until the FSM has been idle for three consecutive cycles
  task automatic settle();
    int idle, n;
    idle = 0;
    n = 0;
    while (idle < 3 && n < 300) begin
      if (busy) idle = 0;
      else      idle++;
      @(posedge clk); #1;
      n++;
    end
    check("settle", 32'(idle >= 3), 1);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int   base, b, nb;
    logic stable, ok;
    int   exp_delta[5] = '{0, 0, 1, 0, 0};

    reset            = 1'b1;
    time_unit_pulse  = 1'b0;
    gens_used        = '0;
    gens_en          = '0;
    bus.prog_gen_idx = '0;
    bus.prog_period  = '0;
    bus.prog_ticks   = '0;
    bus.prog_tag     = '0;
    bus.prog_sign    = 1'b0;
    bus.prog_v       = 1'b0;
    bus.out_a        = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_v", bus.out_v, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_out_ct", bus.out_ct, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_prog_a", bus.prog_a, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_prog_a", bus.prog_a, 1);

    // Empty bank, gens_used 3: four SCAN cycles and nothing emitted
    gens_used = 8'd3;
    gens_en   = '1;
    base = words;
    pulse();
    settle();
    check("empty_words", words - base, 0);
`ifdef SPIKE_GEN_STATS_EN
    check("stats_max_scan", max_scan_cycles, 16'd4);
`endif

    // Period 3, ticks 0: fires on pulses 1 and 4
    gens_used = 8'd0;
    gens_en   = 256'h1;
    program_gen(0, 3, 0, 'h05A, 1'b0);
    base = words;
    pulse();
    check("t1_out_v_t1", bus.out_v, 0);
    @(posedge clk); #1;
    check("t1_out_v_t2", bus.out_v, 1);
    check("t1_tag", bus.out_tag, 11'h05A);
    check("t1_ct", bus.out_ct, 9'h001);
    settle();
    check("t1_pulse1_words", words - base, 1);
    for (int k = 0; k < 5; k++) begin
      b = words;
      pulse();
      settle();
      check("t1_pulse_words", words - b, exp_delta[k]);
    end
    check("t1_w2_tag", tag_at(base + 1), 11'h05A);
    check("t1_w2_ct", ct_at(base + 1), 9'h001);

    // Gens 0..3 period 1, gen 2 disabled
    gens_used = 8'd3;
    gens_en   = 256'hB;
    program_gen(0, 1, 0, 1, 1'b0);
    program_gen(1, 1, 0, 2, 1'b0);
    program_gen(2, 1, 0, 3, 1'b1);
    program_gen(3, 1, 0, 4, 1'b0);
    base = words;
    pulse();
    wait_idle(nb);
    check("t2_busy_cycles", nb, 7);
    settle();
    check("t2_words", words - base, 3);
    check("t2_tag0", tag_at(base), 11'd1);
    check("t2_tag1", tag_at(base + 1), 11'd2);
    check("t2_tag2", tag_at(base + 2), 11'd4);
    check("t2_ct0", ct_at(base), 9'h001);
    check("t2_ct1", ct_at(base + 1), 9'h001);
    check("t2_ct2", ct_at(base + 2), 9'h001);
`ifdef SPIKE_GEN_STATS_EN
    check("stats_spike_count", spike_count, 32'd5);
`endif

    // Backpressure, pending and overrun
    reset_dut();
    gens_used = 8'd1;
    gens_en   = 256'h3;
    program_gen(0, 1, 0, 'h10, 1'b0);
    program_gen(1, 1, 0, 'h11, 1'b1);
    bus.out_a = 1'b0;
    base = words;
    pulse();
    @(posedge clk); #1;
    check("t3_out_v", bus.out_v, 1);
    check("t3_tag", bus.out_tag, 11'h010);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      time_unit_pulse = (i == 1 || i == 4);
      @(posedge clk); #1;
      if (bus.out_v !== 1'b1 || bus.out_tag !== 11'h010 || bus.out_ct !== 9'h001)
        stable = 1'b0;
      if (i == 3) check("t3_overrun_after_2nd", overrun, 0);
    end
    time_unit_pulse = 1'b0;
    check("t3_stable", stable, 1);
    check("t3_overrun_after_3rd", overrun, 1);
    check("t3_held_words", words - base, 0);
    bus.out_a = 1'b1;
    settle();
    check("t3_words", words - base, 4);
    check("t3_tag0", tag_at(base), 11'h010);
    check("t3_tag1", tag_at(base + 1), 11'h011);
    check("t3_ct1", ct_at(base + 1), 9'h1FF);
    check("t3_tag2", tag_at(base + 2), 11'h010);
    check("t3_tag3", tag_at(base + 3), 11'h011);
    check("t3_overrun_sticky", overrun, 1);

    // Programming blocked during a scan, lands afterwards
    reset_dut();
    gens_used = 8'd2;
    gens_en   = 256'h7;
    program_gen(0, 1, 0, 'h20, 1'b0);
    bus.out_a = 1'b0;
    base = words;
    pulse();
    @(posedge clk); #1;
    bus.prog_gen_idx = 8'd1;
    bus.prog_period  = 16'd2;
    bus.prog_ticks   = 16'd0;
    bus.prog_tag     = 11'h033;
    bus.prog_sign    = 1'b0;
    bus.prog_v       = 1'b1;
    #1;
    check("t4_prog_a_busy", bus.prog_a, 0);
    repeat (3) @(posedge clk);
    #1;
    bus.out_a = 1'b1;
    ok = 1'b1;
    nb = 0;
    while (busy && nb < 50) begin
      if (bus.prog_a) ok = 1'b0;
      @(posedge clk); #1;
      nb++;
    end
    check("t4_prog_a_low_in_scan", ok, 1);
    check("t4_prog_a_idle", bus.prog_a, 1);
    @(posedge clk); #1;
    bus.prog_v = 1'b0;
    check("t4_scan_words", words - base, 1);
    program_gen(2, 0, 0, 'h44, 1'b0);
    b = words;
    pulse();
    settle();
    check("t4_words_a", words - b, 2);
    check("t4_tag_a0", tag_at(b), 11'h020);
    check("t4_tag_a1", tag_at(b + 1), 11'h033);
    b = words;
    pulse();
    settle();
    check("t4_words_b", words - b, 1);
    check("t4_tag_b0", tag_at(b), 11'h020);

    // Asynchronous reset while in EMIT
    bus.out_a = 1'b0;
    pulse();
    @(posedge clk); #1;
    check("t5_emit_out_v", bus.out_v, 1);
    pulse();
    pulse();
    check("t5_overrun_set", overrun, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_out_v", bus.out_v, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_overrun", overrun, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_a = 1'b1;
    b = words;
    pulse();
    settle();
    check("t5_no_words", words - b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_gen_scheduler.md
Name: spike_gen_scheduler

Overview:
- Sequences the FPGA spike-generator bank.
- Holds per-generator programming (period, ticks, tag, sign), written through the spike-generator programming channel.
- On each wall-clock time-unit pulse from the time manager, scans generators 0..gens_used once.
- Emits one tag/count word per generator whose tick counter expires, onto a TagCt channel toward the tag merge.

Parameters:
- Ngens, 8, generator index width; the bank holds 2**Ngens entries.
- Nperiod, 16, period/ticks width.
- Ntag, 11, tag width.
- Nct, 9, count width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- time_unit_pulse  in  1  one-cycle strobe per wall-clock time unit.
- gens_used  in  Ngens  highest generator index scanned.
- gens_en  in  2**Ngens  per-generator enable.
- prog_gen_idx  in  Ngens  entry to write.
- prog_period  in  Nperiod  period in time units; 0 = generator off.
- prog_ticks  in  Nperiod  initial countdown.
- prog_tag  in  Ntag  tag emitted.
- prog_sign  in  1  1 = emit count -1.
- prog_v  in  1  programming valid.
- prog_a  out  1  programming ack.
- out_tag  out  Ntag  emitted tag.
- out_ct  out  Nct  emitted count.
- out_v  out  1  output valid.
- out_a  in  1  output ack.
- busy  out  1  scan in progress.
- overrun  out  1  sticky: a time unit was dropped.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; scan index = 0; pending = 0; overrun = 0.
  - out_v = 0, out_tag = 0, out_ct = 0, busy = 0, prog_a = 0.
  - All entries cleared: period 0, ticks 0, tag 0, sign 0.
  - Reset mid-scan or mid-EMIT abandons the word in flight; no partial transfer.
- Handshakes:
  - A transfer occurs on a rising clk edge with v and a both high.
  - out_tag and out_ct are registered and hold stable while out_v is high and out_a is low.
  - out_v deasserts the cycle after a transfer.
- Programming:
  - prog_a = 1 only in IDLE with pending = 0 (combinational from state).
  - On transfer, the entry at prog_gen_idx is fully overwritten.
  - Programming is never accepted during a scan.
- State machine:
  - IDLE: if time_unit_pulse or pending is set -> SCAN with index 0; pending is cleared.
  - SCAN (one generator per cycle):
    - Skipped (no update) if gens_en[idx] = 0 or period = 0.
    - Else if ticks = 0: ticks <= period-1; load out_tag = tag; out_ct = sign ? all-ones (-1, 9'h1FF) : 1 (9'h001); assert out_v; -> EMIT.
    - Else ticks <= ticks-1.
    - After a non-firing evaluation: if idx = gens_used -> IDLE, else idx+1.
  - EMIT: wait for out_a. On transfer: if idx = gens_used -> IDLE, else idx+1 and -> SCAN.
- Latency: pulse at cycle t -> generator 0 evaluated at t+1 -> out_v at t+2 if it fires.
- busy = 1 in SCAN and EMIT.
- Pulse while busy: pending <= 1.
- Pulse while busy with pending already 1: overrun <= 1. overrun clears only on reset.
- Pulse in the same cycle the FSM returns to IDLE: pending is set, and a new scan starts the next cycle.
- Boundary cases:
  - gens_used = 0 scans generator 0 only.
  - gens_used = 2**Ngens-1 wraps nothing; the FSM returns to IDLE.
  - Period 1 fires every time unit.
  - Ticks arithmetic is unsigned; ticks = 0 never decrements below 0.

Optional Feature:
SPIKE_GEN_STATS_EN
- Defined:
  - Adds output spike_count (32 bits), incremented on every out transfer; wraps modulo 2**32; reset 0.
  - Adds output max_scan_cycles (16 bits): largest cycle count from SCAN entry to IDLE return; saturates at 16'hFFFF; reset 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Program gen 0: period 3, ticks 0, tag 11'h05A, sign 0; gens_used 0; gens_en bit 0 set; six pulses, out_a tied 1 -> words on pulses 1 and 4 only, each out_tag 0x05A, out_ct 9'h001; first out_v 2 cycles after pulse 1.
- Gens 0..3 all period 1, tags 1..4, gen 2 sign 1; gens_en = 4'b1011; one pulse -> words for tags 1, 2, 4 in order, all out_ct 9'h001; gen 2 silent; busy drops after index 3.
- Hold out_a low 10 cycles on the first word -> out_v, out_tag and out_ct stable; no index advance; second pulse sets pending; third pulse sets overrun = 1; after ack, the pending scan runs exactly once.
- prog_v asserted during a scan -> prog_a = 0 until IDLE; the write lands after the scan; period 0 entry never emits.
- Assert reset while in EMIT -> out_v, busy and overrun go 0 without waiting for a clock edge; a later pulse with no reprogramming emits nothing.
- SPIKE_GEN_STATS_EN: 5 words transferred -> spike_count = 5; with gens_used 3, no fires, max_scan_cycles = 4.
